uart_responder: RTL
===================

// Module: uart_responder
// PURPOSE
//   Soft UART peripheral that acts as the device end of the board's parallel UART
//   handshake (rdn/wrn strobes, data_ready/tbre/tsre status). It replaces the external
//   UART chip inside the FPGA.
//   - Serialises bytes written by the memory/UART controller onto txd.
//   - Deserialises rxd into a receive buffer that the controller reads.
//   - Sits between the controller's UART pins and the board serial pins. A top-level
//     tristate merges data_out/data_oe onto the shared data bus.
// PARAMETERS
//   CLK_DIV  16  clk cycles per serial bit; must be an even value >= 4
// PORTS
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   rdn         in   1  read strobe, active low
//   wrn         in   1  write strobe, active low
//   data_in     in   8  bus data captured on a write (low byte of the bus)
//   data_out    out  8  receive-buffer byte presented during a read
//   data_oe     out  1  1 = drive data_out onto the bus
//   data_ready  out  1  1 = unread byte in the receive buffer
//   tbre        out  1  1 = transmit holding register empty
//   tsre        out  1  1 = transmit shift register empty, line idle
//   txd         out  1  serial out, idle high
//   rxd         in   1  serial in, asynchronous
//   rx_overrun  out  1  sticky: a received byte was lost; clears on read
//   frame_err   out  1  sticky: a stop bit was sampled 0; clears on read
// BEHAVIOUR
//   Reset (async, rst=0): txd=1, tbre=1, tsre=1, data_ready=0, data_oe=0,
//     data_out=0, rx_overrun=0, frame_err=0; both FSMs go to IDLE.
//     Reset mid-frame aborts the frame immediately. txd returns to 1.
//   Strobes: rdn/wrn are registered once (rdn_q, wrn_q).
//     Write event (W) = wrn_q==0 && wrn==1. Read end (R) = rdn_q==0 && rdn==1.
//   Write:
//     - On W with tbre=1: thr<=data_in; tbre=0 the next cycle.
//     - On W with tbre=0: the write is ignored and thr is unchanged.
//   TX FSM, states IDLE, START, DATA, STOP. Bit counter 0..7; baud counter 0..CLK_DIV-1.
//     - IDLE: if tbre=0, load shifter<=thr, tbre<=1, tsre<=0, go to START.
//       Hence W at edge E gives tbre=0 at E+1, tbre=1 at E+2, tsre=0 at E+2,
//       and the txd start bit from E+2.
//     - START drives txd=0; DATA sends bits LSB first; STOP drives txd=1.
//       Each state lasts CLK_DIV cycles per bit.
//     - At the end of STOP: if tbre=0, reload directly to START (back-to-back frame,
//       tsre stays 0); otherwise tsre<=1 and go to IDLE.
//   RX path: rxd passes through a 2-flop synchroniser (rxs).
//   RX FSM, states IDLE, START, DATA, STOP.
//     - IDLE: rxs==0 moves to START.
//     - START: sample at CLK_DIV/2. If rxs==1, it was a glitch; return to IDLE.
//     - DATA: sample each bit every CLK_DIV cycles at mid-bit, LSB first.
//     - STOP: sample at mid-bit, then return to IDLE at that sample (completion C).
//   On C with stop bit=1 (good byte):
//     - data_ready=0, rdn high: rx_buf<=byte, data_ready<=1.
//     - data_ready=1, rdn high: rx_buf unchanged; new byte dropped; rx_overrun<=1.
//     - rdn low (read in progress): rx_buf is frozen. Byte goes to a 1-deep pending
//       register (pend_v=1). If pend_v was already 1, the byte is dropped and
//       rx_overrun<=1.
//   On C with stop bit=0: byte discarded, frame_err<=1, buffers untouched.
//   Read:
//     - While rdn_q==0: data_oe=1, data_out=rx_buf. rx_buf does not change while rdn low.
//     - When rdn_q==1: data_oe=0; data_out holds its last value.
//     - On R: rx_overrun<=0, frame_err<=0.
//       If pend_v: rx_buf<=pend, pend_v<=0, data_ready stays 1.
//       Otherwise data_ready<=0.
//     - R and C in the same cycle: R is processed first, then C. A good byte then
//       lands in rx_buf with data_ready=1 and no overrun.
//     - A read with data_ready=0 returns stale rx_buf and has no side effects
//       beyond clearing the flags.
//   TX and RX are fully independent; simultaneous W and R are both honoured.
// TESTING
//   1. CLK_DIV=16, W with data_in=8'hA5, tsre=1:
//      tbre 0->1 at E+1/E+2; txd=0,1,0,1,0,0,1,0,1,1, 16 cycles per bit; tsre=1 after stop.
//   2. Two W (8'h01 then 8'h02), second W issued once tbre=1 during frame 1:
//      frames are back to back; tsre stays 0 between them; a third W with tbre=0 is ignored.
//   3. Drive rxd frame 8'h3C: data_ready=1 after stop-bit sample.
//      rdn low -> data_oe=1, data_out=8'h3C. rdn high -> data_ready=0.
//   4. Send 8'h11 then 8'h22 with no read:
//      rx_buf=8'h11, rx_overrun=1. After a read: data_ready=0, rx_overrun=0.
//   5. Hold rdn low while 8'h77 completes, with 8'h66 buffered:
//      data_out stays 8'h66. On R: rx_buf=8'h77, data_ready=1.
//   6. Inject 4-cycle rxd low glitch -> no byte; stop bit forced 0 -> frame_err=1;
//      rst low mid-TX-frame -> txd=1, tbre=1, tsre=1 at once.

Source files
------------

// File: rtl/uart_responder.sv
// Soft UART device: parallel rdn/wrn strobe interface on one side, txd/rxd serial pins on the other.
// Single-byte transmit holding register, receive buffer with one-deep pending slot for reads in progress.
module uart_responder #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] HALF_TC = BW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t tx_state, tx_next, rx_state, rx_next;

  logic          rdn_q, wrn_q, w_evt, r_evt;
  logic [7:0]    thr, tx_shift;
  logic [BW-1:0] tx_baud, rx_baud;
  logic [2:0]    tx_bit, rx_bit;
  logic          tx_tick, tx_load, tx_idle;
  logic          rx_meta, rxs, rx_tick, rx_done;
  logic [7:0]    rx_shift, rx_buf, pend, dout_hold;
  logic          pend_v;
  logic [7:0]    buf_n, pend_n;
  logic          dr_n, pv_n, ov_n, fe_n;

  assign w_evt   = !wrn_q && wrn;
  assign r_evt   = !rdn_q && rdn;
  assign data_oe = !rdn_q;
  assign data_out = rdn_q ? dout_hold : rx_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      dout_hold <= 8'h00;
    end else begin
      rdn_q <= rdn;
      wrn_q <= wrn;
      if (!rdn_q) dout_hold <= rx_buf;
    end
  end

  // Transmit: a reload at the end of STOP keeps frames back to back.
  always_comb begin
    tx_next = tx_state;
    tx_tick = (tx_baud == '0);
    tx_load = 1'b0;
    tx_idle = 1'b0;
    txd     = 1'b1;
    case (tx_state)
      IDLE: if (!tbre) begin
        tx_load = 1'b1;
        tx_next = START;
      end
      START: begin
        txd = 1'b0;
        if (tx_tick) tx_next = DATA;
      end
      DATA: begin
        txd = tx_shift[0];
        if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
      end
      STOP: if (tx_tick) begin
        if (!tbre) begin
          tx_load = 1'b1;
          tx_next = START;
        end else begin
          tx_idle = 1'b1;
          tx_next = IDLE;
        end
      end
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      thr      <= 8'h00;
      tx_shift <= 8'h00;
      tx_baud  <= BAUD_TC;
      tx_bit   <= 3'd0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_load) begin
        tx_shift <= thr;
        tbre     <= 1'b1;
        tsre     <= 1'b0;
        tx_baud  <= BAUD_TC;
        tx_bit   <= 3'd0;
      end else if (tx_state != IDLE) begin
        if (tx_tick) begin
          tx_baud <= BAUD_TC;
          if (tx_state == DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_baud <= tx_baud - BW'(1);
        end
      end
      if (tx_idle) tsre <= 1'b1;
      if (w_evt && tbre) begin
        thr  <= data_in;
        tbre <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_tick = (rx_baud == '0);
    rx_done = 1'b0;
    case (rx_state)
      IDLE:  if (!rxs) rx_next = START;
      START: if (rx_tick) rx_next = rxs ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
      STOP: if (rx_tick) begin
        rx_done = 1'b1;
        rx_next = IDLE;
      end
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_state <= IDLE;
      rx_baud  <= HALF_TC;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rx_state <= rx_next;
      case (rx_state)
        IDLE: begin
          rx_baud <= HALF_TC;
          rx_bit  <= 3'd0;
        end
        default: begin
          if (rx_tick) begin
            rx_baud <= BAUD_TC;
            if (rx_state == DATA) begin
              rx_shift <= {rxs, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
            end
          end else begin
            rx_baud <= rx_baud - BW'(1);
          end
        end
      endcase
    end
  end

  // Read end is applied before a same-cycle completion so the new byte can land.
  always_comb begin
    buf_n  = rx_buf;
    pend_n = pend;
    dr_n   = data_ready;
    pv_n   = pend_v;
    ov_n   = rx_overrun;
    fe_n   = frame_err;
    if (r_evt) begin
      ov_n = 1'b0;
      fe_n = 1'b0;
      if (pend_v) begin
        buf_n = pend;
        pv_n  = 1'b0;
      end else begin
        dr_n = 1'b0;
      end
    end
    if (rx_done) begin
      if (!rxs) begin
        fe_n = 1'b1;
      end else if (rdn) begin
        if (!dr_n) begin
          buf_n = rx_shift;
          dr_n  = 1'b1;
        end else begin
          ov_n = 1'b1;
        end
      end else if (pv_n) begin
        ov_n = 1'b1;
      end else begin
        pend_n = rx_shift;
        pv_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf     <= 8'h00;
      pend       <= 8'h00;
      data_ready <= 1'b0;
      pend_v     <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_buf     <= buf_n;
      pend       <= pend_n;
      data_ready <= dr_n;
      pend_v     <= pv_n;
      rx_overrun <= ov_n;
      frame_err  <= fe_n;
    end
  end

endmodule
